awgn_rx_demod: RTL and testbench

// - Receive end of the AWGN channel link: consumes the channel's noisy signed 16-bit antipodal

---
 rtl/awgn_link_pkg.sv | 27 ++
 rtl/awgn_integrate_dump.sv | 92 +++++++++
 rtl/awgn_rx_demod.sv | 109 ++++++++++
 tb/tb_awgn_rx_demod.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/awgn_link_pkg.sv
// Shared link constants and types for the AWGN transmit/receive pair.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package awgn_link_pkg;

  localparam int SAMPLE_W = 16;
  localparam int BYTE_W   = 8;

  // Bit value carried by a positive integrated amplitude; the transmit mapper
  // must use the same polarity or every recovered bit comes out inverted.
  localparam logic POS_AMP_BIT = 1'b1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [BYTE_W-1:0]   byte_t;

  typedef struct packed {
    logic value;
    logic erased;
  } bit_dec_t;

  // Map "integrated amplitude is strictly positive" onto a bit value.
  // A zero total is not positive, so it always takes the negative-amplitude value.
  function automatic logic slice_bit(input logic positive);
    return positive ? POS_AMP_BIT : ~POS_AMP_BIT;
  endfunction

endpackage

// File: rtl/awgn_integrate_dump.sv
// Integrate-and-dump over SPB samples per bit, sign slicer and erasure compare.
// Latency: decision registered, strobe 1 clk after the last sample of a bit.
// Backpressure: none; every valid sample is consumed, idle cycles hold state.
module awgn_integrate_dump
  import awgn_link_pkg::*;
#(
  parameter int SPB          = 8,
  parameter int ERASE_THRESH = 2048
) (
  input  logic     clk,
  input  logic     reset,
  input  sample_t  in_sample,
  input  logic     in_valid,
  input  logic     bit_align,
  output logic     dec_strobe,
  output bit_dec_t dec
);

  localparam int LOG2_SPB = $clog2(SPB);
  // Wide enough that SPB full-scale samples of either sign cannot overflow.
  localparam int ACC_W    = SAMPLE_W + LOG2_SPB;

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [LOG2_SPB-1:0] samp_cnt_q, samp_cnt_d;
  logic                       strobe_q, strobe_d;
  bit_dec_t                   dec_q, dec_d;

  logic signed [ACC_W-1:0]    samp_ext;
  logic signed [ACC_W-1:0]    total;
  logic        [ACC_W-1:0]    tot_u;
  logic        [ACC_W-1:0]    mag;
  logic        [ACC_W-1:0]    mag_scaled;
  logic                       last_samp;
  logic                       positive;
  logic                       erased;

  // Running sum, magnitude of the bit total (unsigned, so the most negative
  // total maps to its true magnitude) and the per-bit decisions.
  always_comb begin
    samp_ext   = {{LOG2_SPB{in_sample[SAMPLE_W-1]}}, in_sample};
    total      = acc_q + samp_ext;
    tot_u      = total;
    mag        = tot_u[ACC_W-1] ? (~tot_u + {{(ACC_W-1){1'b0}}, 1'b1}) : tot_u;
    mag_scaled = mag >> LOG2_SPB;
    erased     = (mag_scaled < ACC_W'(ERASE_THRESH));
    positive   = !total[ACC_W-1] && (total != '0);
    last_samp  = (samp_cnt_q == LOG2_SPB'(SPB - 1));
  end

  // Next state: align restarts the window with this sample, the last sample
  // of a window dumps and decides, anything else keeps integrating.
  always_comb begin
    acc_d      = acc_q;
    samp_cnt_d = samp_cnt_q;
    strobe_d   = 1'b0;
    dec_d      = dec_q;
    if (in_valid) begin
      if (bit_align) begin
        acc_d      = samp_ext;
        samp_cnt_d = LOG2_SPB'(1);
      end else if (last_samp) begin
        acc_d        = '0;
        samp_cnt_d   = '0;
        strobe_d     = 1'b1;
        dec_d.value  = slice_bit(positive);
        dec_d.erased = erased;
      end else begin
        acc_d      = total;
        samp_cnt_d = samp_cnt_q + LOG2_SPB'(1);
      end
    end
  end

  // State registers; reset discards any partial bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      samp_cnt_q <= '0;
      strobe_q   <= 1'b0;
      dec_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      samp_cnt_q <= samp_cnt_d;
      strobe_q   <= strobe_d;
      dec_q      <= dec_d;
    end
  end

  assign dec_strobe = strobe_q;
  assign dec        = dec_q;

endmodule

// File: rtl/awgn_rx_demod.sv
// AWGN receive demodulator: integrate-and-dump bits, pack MSB-first into bytes.
// Latency: bit_strobe 1 clk after a bit's last sample; out_valid 1 clk after the 8th strobe.
// Backpressure: single-entry output; a byte completing while the held one is unconsumed is dropped and flagged in overrun.
module awgn_rx_demod
  import awgn_link_pkg::*;
#(
  parameter int SPB          = 8,
  parameter int ERASE_THRESH = 2048,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                in_valid,
  input  logic                bit_align,
  output logic [BYTE_W-1:0]   out_byte,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                bit_strobe,
  output logic                bit_value,
  output logic                bit_erased,
  output logic [CNT_W-1:0]    erase_count,
  output logic                overrun
);

  localparam int BIT_CNT_W = $clog2(BYTE_W);

  logic     dec_strobe;
  bit_dec_t dec;

  awgn_integrate_dump #(
    .SPB          (SPB),
    .ERASE_THRESH (ERASE_THRESH)
  ) u_int_dump (
    .clk        (clk),
    .reset      (reset),
    .in_sample  (sample_t'(in_sample)),
    .in_valid   (in_valid),
    .bit_align  (bit_align),
    .dec_strobe (dec_strobe),
    .dec        (dec)
  );

  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  byte_t                shift_q, shift_d;
  byte_t                out_byte_q, out_byte_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_W-1:0]     erase_count_q, erase_count_d;
  logic                 overrun_q, overrun_d;
  logic                 byte_done;

  // Pack decisions, count erasures and manage the single output slot.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    out_byte_d    = out_byte_q;
    out_valid_d   = out_valid_q;
    erase_count_d = erase_count_q;
    overrun_d     = overrun_q;
    byte_done     = dec_strobe && (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));

    if (dec_strobe) begin
      shift_d   = {shift_q[BYTE_W-2:0], dec.value};
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      if (dec.erased && (erase_count_q != '1)) begin
        erase_count_d = erase_count_q + CNT_W'(1);
      end
    end

    if (byte_done) begin
      if (!out_valid_q || out_ready) begin
        out_byte_d  = shift_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops partial bytes, the held byte and the statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      out_byte_q    <= '0;
      out_valid_q   <= 1'b0;
      erase_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      out_byte_q    <= out_byte_d;
      out_valid_q   <= out_valid_d;
      erase_count_q <= erase_count_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_byte    = out_byte_q;
  assign out_valid   = out_valid_q;
  assign bit_strobe  = dec_strobe;
  assign bit_value   = dec.value;
  assign bit_erased  = dec.erased;
  assign erase_count = erase_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_awgn_rx_demod.sv
// Directed bench for awgn_rx_demod with a byte scoreboard.
// Expected bytes are queued as stimulus is sent and popped on each handshake.
module tb_awgn_rx_demod;

  localparam int SPB = 8;
  localparam int AMP = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_sample;
  logic        in_valid;
  logic        bit_align;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        bit_strobe;
  logic        bit_value;
  logic        bit_erased;
  logic [15:0] erase_count;
  logic        overrun;

  int checks     = 0;
  int failures   = 0;
  int strobe_cnt = 0;
  int valid_cyc  = 0;
  int sc;
  int vc;
  logic [7:0] sb[$];

  awgn_rx_demod #(
    .SPB          (SPB),
    .ERASE_THRESH (2048),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .bit_align   (bit_align),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .bit_strobe  (bit_strobe),
    .bit_value   (bit_value),
    .bit_erased  (bit_erased),
    .erase_count (erase_count),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bit_strobe === 1'b1) strobe_cnt++;
      if (out_valid === 1'b1) valid_cyc++;
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        logic [7:0] e;
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_byte", 32'(out_byte), 32'(e));
        end
      end
    end
  end

  task automatic drive(input int s, input logic a);
    in_sample = 16'(s);
    in_valid  = 1'b1;
    bit_align = a;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    bit_align = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_const(input int v);
    for (int i = 0; i < SPB; i++) drive(v, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    send_const(b ? AMP : -AMP);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Same byte, with random idle cycles after some samples; no strobe may
  // appear on any idle cycle.
  task automatic send_byte_gaps(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      for (int k = 0; k < SPB; k++) begin
        drive(b[i] ? AMP : -AMP, 1'b0);
        if ($urandom_range(0, 2) == 0) begin
          int n;
          n = int'($urandom_range(1, 3));
          for (int g = 0; g < n; g++) begin
            idle(1);
            chk("gap_no_strobe", 32'(bit_strobe), 32'd0);
          end
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_sample = '0;
    in_valid  = 1'b0;
    bit_align = 1'b0;
    out_ready = 1'b1;
    #1 reset  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_byte", 32'(out_byte), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bit_strobe", 32'(bit_strobe), 32'd0);
    chk("rst_bit_value", 32'(bit_value), 32'd0);
    chk("rst_bit_erased", 32'(bit_erased), 32'd0);
    chk("rst_erase_count", 32'(erase_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Noise-free byte A5
    sc = strobe_cnt;
    vc = valid_cyc;
    sb.push_back(8'hA5);
    send_byte(8'hA5);
    idle(3);
    chk("a5_strobes", 32'(strobe_cnt - sc), 32'd8);
    chk("a5_valid_cycles", 32'(valid_cyc - vc), 32'd1);
    chk("a5_erase_count", 32'(erase_count), 32'd0);

    // Erasure byte 1,0,0,1,0,1,1,0 = 96
    sb.push_back(8'h96);
    send_const(100);
    chk("weak_strobe", 32'(bit_strobe), 32'd1);
    chk("weak_value", 32'(bit_value), 32'd1);
    chk("weak_erased", 32'(bit_erased), 32'd1);
    idle(1);
    chk("weak_count", 32'(erase_count), 32'd1);
    for (int i = 0; i < SPB; i++) drive((i % 2 == 0) ? 4000 : -4000, 1'b0);
    chk("zero_value", 32'(bit_value), 32'd0);
    chk("zero_erased", 32'(bit_erased), 32'd1);
    idle(1);
    chk("zero_count", 32'(erase_count), 32'd2);
    send_const(-32768);
    chk("minneg_value", 32'(bit_value), 32'd0);
    chk("minneg_erased", 32'(bit_erased), 32'd0);
    send_const(2048);
    chk("thresh_value", 32'(bit_value), 32'd1);
    chk("thresh_erased", 32'(bit_erased), 32'd0);
    send_const(-2047);
    chk("below_value", 32'(bit_value), 32'd0);
    chk("below_erased", 32'(bit_erased), 32'd1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    idle(3);
    chk("erase_total", 32'(erase_count), 32'd3);
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // Backpressure: 3C held, FF dropped
    out_ready = 1'b0;
    sb.push_back(8'h3C);
    send_byte(8'h3C);
    send_byte(8'hFF);
    idle(3);
    chk("bp_out_byte", 32'(out_byte), 32'h3C);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_valid_falls", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    sb.push_back(8'h01);
    send_byte(8'h01);
    idle(3);

    // Alignment mid-byte: bits 1,0 | partial discarded | 1,0,0,1,1,0 -> A6
    sb.push_back(8'hA6);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) drive(-AMP, 1'b0);
    sc = strobe_cnt;
    drive(AMP, 1'b1);
    for (int i = 0; i < SPB - 2; i++) drive(AMP, 1'b0);
    idle(1);
    chk("align_no_early_strobe", 32'(strobe_cnt - sc), 32'd0);
    drive(AMP, 1'b0);
    chk("align_strobe", 32'(bit_strobe), 32'd1);
    chk("align_value", 32'(bit_value), 32'd1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    idle(3);

    // in_valid gaps
    sc = strobe_cnt;
    sb.push_back(8'h5A);
    send_byte_gaps(8'h5A);
    idle(3);
    chk("gap_strobes", 32'(strobe_cnt - sc), 32'd8);
    chk("gap_out_byte", 32'(out_byte), 32'h5A);

    // Reset after 5 bits plus a partial bit
    chk("overrun_sticky", 32'(overrun), 32'd1);
    send_const(100);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    idle(1);
    chk("pre_rst_count", 32'(erase_count), 32'd4);
    for (int i = 0; i < 3; i++) drive(AMP, 1'b0);
    reset = 1'b0;
    #2;
    chk("mid_rst_out_byte", 32'(out_byte), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_erase_count", 32'(erase_count), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_bit_value", 32'(bit_value), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sc = strobe_cnt;
    sb.push_back(8'hC3);
    send_byte(8'hC3);
    idle(3);
    chk("post_rst_strobes", 32'(strobe_cnt - sc), 32'd8);
    chk("post_rst_out_byte", 32'(out_byte), 32'hC3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
